// File: rtl/cpu_trace_pkg.sv
// Shared types for the writeback trace capture path.
// One FIFO entry holds a single register-file commit.
package cpu_trace_pkg;

  localparam int TRACE_DEPTH_DEFAULT = 8;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries, wrap-bit pointers.
// A push while full is accepted when a pop frees the slot in the same cycle.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  trace_entry_t push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output trace_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t mem_q [DEPTH];

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        push_ok;
  logic        pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0])
                && (wr_q[AW] != rd_q[AW]);

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign wr_d = push_ok ? wr_q + 1'b1 : wr_q;
  assign rd_d = pop_ok  ? rd_q + 1'b1 : rd_q;

  assign head_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_trace_capture.sv
// Passive capture of writeback commits into a drainable FIFO,
// with commit/drop statistics. Never stalls the CPU.
module wb_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH   = TRACE_DEPTH_DEFAULT,
  parameter int SKIP_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           debug_wb_pc,
  input  logic                  debug_wb_rf_wen,
  input  logic [4:0]            debug_wb_rf_addr,
  input  logic [31:0]           debug_wb_rf_wdata,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_pc,
  output logic [4:0]            trace_addr,
  output logic [31:0]           trace_wdata,
  output logic [31:0]           commit_count,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  overflow
);

  logic         qual;
  logic         pop;
  logic         full;
  logic         empty;
  logic         drop;
  trace_entry_t in_e;
  trace_entry_t head;

  logic [31:0]           commit_q, commit_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ovf_q, ovf_d;

  assign qual = debug_wb_rf_wen
             && ((SKIP_R0 == 0) || (debug_wb_rf_addr != 5'd0));

  assign trace_valid = !empty;
  assign pop  = trace_valid && trace_ready;
  assign drop = qual && full && !pop;

  assign in_e.pc    = debug_wb_pc;
  assign in_e.addr  = debug_wb_rf_addr;
  assign in_e.wdata = debug_wb_rf_wdata;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (qual),
    .push_data_i (in_e),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head)
  );

  assign trace_pc    = head.pc;
  assign trace_addr  = head.addr;
  assign trace_wdata = head.wdata;

  always_comb begin
    commit_d = commit_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (qual) commit_d = commit_q + 32'd1;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      commit_q <= commit_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign commit_count = commit_q;
  assign drop_count   = drop_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture, DEPTH=8, SKIP_R0=1.
module tb_wb_trace_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        valid;
  logic        ready;
  logic [31:0] t_pc;
  logic [4:0]  t_addr;
  logic [31:0] t_wdata;
  logic [31:0] ccnt;
  logic [15:0] dcnt;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_trace_capture #(
    .DEPTH   (8),
    .SKIP_R0 (1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .debug_wb_pc       (pc),
    .debug_wb_rf_wen   (wen),
    .debug_wb_rf_addr  (addr),
    .debug_wb_rf_wdata (wdata),
    .trace_valid       (valid),
    .trace_ready       (ready),
    .trace_pc          (t_pc),
    .trace_addr        (t_addr),
    .trace_wdata       (t_wdata),
    .commit_count      (ccnt),
    .drop_count        (dcnt),
    .overflow          (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic commit(input logic [31:0] p,
                        input logic [4:0]  a,
                        input logic [31:0] d);
    wen   = 1'b1;
    pc    = p;
    addr  = a;
    wdata = d;
    step();
    wen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wen   = 1'b0;
    pc    = '0;
    addr  = '0;
    wdata = '0;
    ready = 1'b0;
    step();
    // a commit presented during reset must be ignored
    wen  = 1'b1;
    addr = 5'd3;
    step();
    wen   = 1'b0;
    rst_n = 1'b1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_commit", ccnt, 32'd0);
    chk("rst_drop", 32'(dcnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    commit(32'h0040_0010, 5'd8, 32'hDEAD_BEEF);
    chk("one_valid", 32'(valid), 32'd1);
    chk("one_pc", t_pc, 32'h0040_0010);
    chk("one_addr", 32'(t_addr), 32'd8);
    chk("one_wdata", t_wdata, 32'hDEAD_BEEF);
    chk("one_commit", ccnt, 32'd1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("one_popped", 32'(valid), 32'd0);

    do_reset();
    commit(32'h100, 5'd0, 32'h1);
    wen   = 1'b0;
    addr  = 5'd5;
    wdata = 32'h2;
    step();
    chk("r0_commit", ccnt, 32'd0);
    chk("r0_valid", 32'(valid), 32'd0);

    do_reset();
    for (int i = 1; i <= 10; i++)
      commit(32'h1000 + 32'(4 * i), 5'd1, 32'(i));
    chk("ovf_drop", 32'(dcnt), 32'd2);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_commit", ccnt, 32'd10);
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_dvalid", 32'(valid), 32'd1);
      chk("ovf_dwdata", t_wdata, 32'(i));
      step();
    end
    chk("ovf_empty", 32'(valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    ready = 1'b0;

    do_reset();
    for (int i = 0; i < 8; i++)
      commit(32'h2000, 5'd2, 32'h100 + 32'(i));
    ready = 1'b1;
    commit(32'h2004, 5'd2, 32'h55);
    chk("fpp_drop", 32'(dcnt), 32'd0);
    chk("fpp_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i < 8; i++) begin
      chk("fpp_wdata", t_wdata, 32'h100 + 32'(i));
      step();
    end
    chk("fpp_last_v", 32'(valid), 32'd1);
    chk("fpp_last", t_wdata, 32'h55);
    step();
    chk("fpp_empty", 32'(valid), 32'd0);

    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      commit(32'h3000 + 32'(4 * i), 5'(i + 1), 32'h200 + 32'(i));
      chk("str_valid", 32'(valid), 32'd1);
      chk("str_wdata", t_wdata, 32'h200 + 32'(i));
      chk("str_addr", 32'(t_addr), 32'(i + 1));
    end
    step();
    chk("str_empty", 32'(valid), 32'd0);
    chk("str_commit", ccnt, 32'd20);
    ready = 1'b0;

    do_reset();
    for (int i = 0; i < 9; i++)
      commit(32'h4000, 5'd4, 32'(i));
    ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ready = 1'b0;
    chk("mid_head", t_wdata, 32'd3);
    chk("mid_ovf", 32'(ovf), 32'd1);
    do_reset();
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_commit", ccnt, 32'd0);
    chk("mid_drop", 32'(dcnt), 32'd0);
    chk("mid_ovf0", 32'(ovf), 32'd0);
    commit(32'h5000, 5'd7, 32'h77);
    chk("post_valid", 32'(valid), 32'd1);
    chk("post_wdata", t_wdata, 32'h77);
    chk("post_commit", ccnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
